lsu_wb_master: RTL and testbench
================================

# lsu_wb_master

Load/store unit bus master that sits directly upstream of the word-addressed Wishbone BRAM slave. It turns one CPU load/store request (byte address, RV32 funct3 width/sign, store data) into a single word-aligned pipelined Wishbone transaction with byte-lane selects. It holds every bus output stable until ack, then returns an aligned, sign- or zero-extended load result with a one-cycle done pulse. Misaligned or invalid requests and bus timeouts are reported as errors without hanging the core.

## Interface
- TIMEOUT, 16: number of cycles in REQ+WAIT before the transaction is abandoned; 0 disables the timeout.
- i_clk  in  1  sole clock; all logic is on posedge.
- i_reset_n  in  1  synchronous reset, active-low.
- i_req  in  1  request strobe; sampled only in IDLE.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  qualifies o_done as failed: misaligned, invalid funct3, or timeout.
- o_rdata  out  32  load result; valid while o_done=1.
- o_wb_stb, o_wb_we  out  1  Wishbone strobe and write enable.
- o_wb_addr  out  32  word address, i_addr >> 2.
- o_wb_data  out  32  lane-replicated store data.
- o_wb_sel  out  4  byte-lane select.
- i_wb_data  in  32  read data.
- i_wb_ack, i_wb_stall  in  1  slave ack and stall.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE with i_req=1:
  - If the request is legal: latch i_we, i_funct3 and i_addr[1:0]; drive o_wb_addr/we/data/sel; go to REQ.
  - Otherwise: go to DONE with error set.
  - i_req while not IDLE is ignored and never queued.
- Illegal requests:
  - Halfword with i_addr[0]=1.
  - Word with i_addr[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 > 010.
- REQ: o_wb_stb=1. Cycle with o_wb_stb && !i_wb_stall means accepted; go to WAIT and o_wb_stb=0 next cycle.
- WAIT: on i_wb_ack, capture i_wb_data and go to DONE.
- i_wb_ack is sampled only in WAIT. Ack seen in IDLE, REQ or DONE is ignored.
- DONE: o_done=1 for exactly one cycle, with o_err and o_rdata valid. Then go to IDLE.
- o_wb_addr, o_wb_we, o_wb_data and o_wb_sel hold constant from entry to REQ until the cycle after ack, because the slave samples sel late.
- Store lanes, with a = addr[1:0]:
  - SB: data = {4{wdata[7:0]}}, sel = 4'b0001 << a.
  - SH: data = {2{wdata[15:0]}}, sel = 4'b0011 << a.
  - SW: data = wdata, sel = 4'b1111.
- Loads drive the same sel pattern; the slave may ignore it.
- Load extract: shifted = rdata >> (8*a).
  - LB/LBU: sign/zero-extend shifted[7:0].
  - LH/LHU: sign/zero-extend shifted[15:0].
  - LW: rdata unchanged.
- Error completion: o_rdata=0, no bus cycle issued.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT: o_wb_stb=0, go to DONE with o_err=1, o_rdata=0. Counter width is $clog2(TIMEOUT+1).

## Timing
- Reset (i_reset_n=0 at a posedge), applied next cycle:
  - state=IDLE, counter=0.
  - All outputs 0: o_busy, o_done, o_err, o_rdata, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel.
- Reset mid-transaction: strobe drops the next cycle and the transaction is abandoned without o_done. A late ack is ignored.
- All outputs are registered.
- Latency, i_req sampled at cycle 0:
  - o_wb_stb high at cycle 1.
  - Accepted at cycle 1 if stall=0.
  - Ack at cycle k ≥ 2 gives o_done at cycle k+1.
- Each stall cycle in REQ adds one cycle.
- With the BRAM slave: write ack at 3, done at 4; read ack at 4, done at 5.
- Error path: o_done=o_err=1 at cycle 1, o_busy high only that cycle.
- Back-to-back: a new i_req is accepted in the cycle after o_done (state IDLE).

## Test plan
- SW addr=0x10, wdata=0xDEADBEEF, BRAM model: o_wb_addr=4, sel=1111, stb high exactly cycle 1; done at cycle 4; word 4 = 0xDEADBEEF.
- SB addr=0x13, wdata=0x000000A5 onto word 0x11223344 -> sel=1000, o_wb_data=0xA5A5A5A5; word becomes 0xA5223344.
- Loads from word 0x80F07F01:
  - LB addr+3 -> 0xFFFFFF80; LBU addr+3 -> 0x00000080.
  - LH addr+2 -> 0xFFFF80F0; LHU addr+0 -> 0x00007F01.
  - LW -> 0x80F07F01, done at cycle 5.
- Misaligned LW addr=0x6, and load funct3=011 -> o_done=o_err=1 at cycle 1, o_rdata=0, o_wb_stb never asserted.
- Stall held 3 cycles, then slave never acks, TIMEOUT=8:
  - stb held high through the stall cycles with addr/sel stable.
  - o_err done pulse when the counter reaches 8.
  - Late ack afterwards ignored, no second o_done.
- i_reset_n=0 while in WAIT -> next cycle all outputs 0, IDLE; subsequent ack ignored; new SW after reset completes normally.

Source files
------------

// File: rtl/lsu_wb_master.sv
// Load/store unit Wishbone master: one CPU load/store request becomes a single
// word-aligned pipelined Wishbone transaction with byte-lane selects. Load
// data is aligned and sign/zero-extended; misaligned or invalid requests and
// bus timeouts complete with an error instead of hanging the core.
module lsu_wb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide.
  localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic          timeout_hit;

  // The counter reaches TIMEOUT on the edge where it would step past LAST.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Request legality: known funct3 for the direction, natural alignment.
  function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = !off[0];
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = !we;
      3'b101:  ok = !we && !off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] sel;
    case (f3[1:0])
      2'b00:   sel = 4'b0001 << off;
      2'b01:   sel = 4'b0011 << off;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] data);
    logic [31:0] sh;
    logic [31:0] r;
    sh = data >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b100:  r = {24'h0, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b101:  r = {16'h0, sh[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

  // Transaction FSM with registered outputs; bus address/data/sel/we are only
  // rewritten on a new legal request, so they stay stable through the ack.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_rdata   <= '0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_wb_sel  <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values and the default pulse clears below are safe.
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            o_busy <= 1'b1;
            if (is_legal(i_we, i_funct3, i_addr[1:0])) begin
              state     <= REQ;
              cnt       <= '0;
              funct3_q  <= i_funct3;
              off_q     <= i_addr[1:0];
              o_wb_stb  <= 1'b1;
              o_wb_we   <= i_we;
              o_wb_addr <= {2'b00, i_addr[31:2]};
              o_wb_data <= lane_data(i_funct3, i_wdata);
              o_wb_sel  <= lane_sel(i_funct3, i_addr[1:0]);
            end else begin
              state   <= DONE;
              o_done  <= 1'b1;
              o_err   <= 1'b1;
              o_rdata <= '0;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (timeout_hit) begin
            state    <= DONE;
            o_wb_stb <= 1'b0;
            o_done   <= 1'b1;
            o_err    <= 1'b1;
            o_rdata  <= '0;
          end else if (!i_wb_stall) begin
            state    <= WAIT;
            o_wb_stb <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (i_wb_ack) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_rdata <= o_wb_we ? 32'h0 : load_extract(funct3_q, off_q, i_wb_data);
          end else if (timeout_hit) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_err   <= 1'b1;
            o_rdata <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Randomized self-checking bench for lsu_wb_master with a behavioural BRAM
// slave and a spec-level reference model (byte-array memory, arithmetic lane
// rules, expected completion cycles).
module tb_lsu_wb_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_stall;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] slave_mem [16];
  logic [31:0] ref_mem   [16];

  lsu_wb_master #(.TIMEOUT(TO)) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_req      (req),
    .i_we       (we),
    .i_funct3   (funct3),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_rdata    (rdata),
    .o_wb_stb   (wb_stb),
    .o_wb_we    (wb_we),
    .o_wb_addr  (wb_addr),
    .o_wb_data  (wb_wdata),
    .o_wb_sel   (wb_sel),
    .i_wb_data  (wb_rdata),
    .i_wb_ack   (wb_ack),
    .i_wb_stall (wb_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are then stable and inputs may be changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    slave_mem[idx] = v;
    ref_mem[idx]   = v;
  endtask

  // One request through the DUT with a scripted slave; everything expected is
  // derived from the request itself.
  task automatic run_txn(input logic t_we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int stall_n, input int lat,
                         input bit no_ack, input bit late_ack, input string name);
    int          bytes, off, idx, exp_done, stall_left, accept_cyc;
    int          stb_cnt, done_cnt, done_cyc, hold_bad;
    bit          legal, ok_f3, got_err, busy_at, busy_after;
    logic [31:0] exp_data, exp_rd, word, got_rd, cap_addr, cap_data;
    logic [7:0]  sel_w;
    logic [3:0]  exp_sel, cap_sel;
    logic        cap_we;

    // Reference model
    bytes = 1 << f3[1:0];
    off   = int'(a % 4);
    idx   = int'(a[5:2]);
    ok_f3 = t_we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    legal = ok_f3 && ((a % bytes) == 0);
    sel_w    = 8'(((1 << bytes) - 1) << off);
    exp_sel  = sel_w[3:0];
    exp_data = (bytes == 1) ? wd[7:0] * 32'h01010101 :
               (bytes == 2) ? wd[15:0] * 32'h00010001 : wd;
    exp_done = !legal ? 1 : (no_ack ? TO + 1 : 2 + stall_n + lat);
    word   = ref_mem[idx] >> (8 * off);
    exp_rd = word;
    if (bytes == 1) exp_rd = (word[7] && !f3[2]) ? (word | 32'hFFFFFF00) : (word & 32'hFF);
    if (bytes == 2) exp_rd = (word[15] && !f3[2]) ? (word | 32'hFFFF0000) : (word & 32'hFFFF);
    if (!legal || no_ack) exp_rd = 32'h0;

    // Drive request for one edge
    req = 1'b1; we = t_we; funct3 = f3; addr = a; wdata = wd;
    stall_left = stall_n; accept_cyc = 0;
    stb_cnt = 0; done_cnt = 0; done_cyc = 0; hold_bad = 0;
    got_err = 1'b0; got_rd = 32'h0; busy_at = 1'b0; busy_after = 1'b1;
    cap_addr = '0; cap_data = '0; cap_sel = '0; cap_we = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      step();
      req = 1'b0;
      if (wb_stb) stb_cnt++;
      if (cyc == 1) begin
        cap_addr = wb_addr; cap_data = wb_wdata; cap_sel = wb_sel; cap_we = wb_we;
      end else if (legal && cyc <= exp_done) begin
        if (wb_addr !== cap_addr || wb_wdata !== cap_data || wb_sel !== cap_sel || wb_we !== cap_we)
          hold_bad++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc; got_err = err; got_rd = rdata; busy_at = busy;
        end
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) busy_after = busy;
      // Slave response for the coming edge
      wb_ack = 1'b0; wb_stall = 1'b0; wb_rdata = $urandom;
      if (wb_stb) begin
        if (stall_left > 0) begin
          wb_stall = 1'b1;
          wb_ack   = 1'b1;      // stray ack while stalled must be ignored
          stall_left--;
        end else begin
          accept_cyc = cyc;
        end
      end
      if (!no_ack && accept_cyc > 0 && cyc == accept_cyc + lat) begin
        wb_ack   = 1'b1;
        wb_rdata = slave_mem[wb_addr[3:0]];
        if (wb_we)
          for (int l = 0; l < 4; l++)
            if (wb_sel[l]) slave_mem[wb_addr[3:0]][8*l +: 8] = wb_wdata[8*l +: 8];
      end
      if (late_ack && done_cyc != 0 && cyc == done_cyc + 1) wb_ack = 1'b1;
      if (done_cyc != 0 && cyc >= done_cyc + 3) break;
    end
    wb_ack = 1'b0; wb_stall = 1'b0;

    check({name, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({name, " done_count"}, 32'(done_cnt), 32'd1);
    check({name, " err"}, 32'(got_err), 32'(!legal || no_ack));
    check({name, " busy_at_done"}, 32'(busy_at), 32'd1);
    check({name, " busy_after"}, 32'(busy_after), 32'd0);
    check({name, " stb_cycles"}, 32'(stb_cnt), legal ? 32'(stall_n + 1) : 32'd0);
    if (!t_we || !legal || no_ack) check({name, " rdata"}, got_rd, exp_rd);
    if (legal) begin
      check({name, " wb_addr"}, cap_addr, {2'b00, a[31:2]});
      check({name, " wb_sel"}, 32'(cap_sel), 32'(exp_sel));
      check({name, " wb_we"}, 32'(cap_we), 32'(t_we));
      check({name, " hold"}, 32'(hold_bad), 32'd0);
      if (t_we) begin
        check({name, " wb_data"}, cap_data, exp_data);
        if (!no_ack)
          for (int l = 0; l < 4; l++)
            if (exp_sel[l]) ref_mem[idx][8*l +: 8] = exp_data[8*l +: 8];
        check({name, " mem"}, slave_mem[idx], ref_mem[idx]);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " flags"}, {27'h0, busy, done, err, wb_stb, wb_we}, 32'h0);
    check({name, " rdata"}, rdata, 32'h0);
    check({name, " wb_addr"}, wb_addr, 32'h0);
    check({name, " wb_data"}, wb_wdata, 32'h0);
    check({name, " wb_sel"}, 32'(wb_sel), 32'h0);
  endtask

  initial begin
    int dcnt;
    logic [2:0] f3;
    logic       w;
    reset_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
    wb_rdata = '0; wb_ack = 1'b0; wb_stall = 1'b0;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    step(); step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Directed cases
    run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 2, 1'b0, 1'b0, "sw");
    check("sw word4", slave_mem[4], 32'hDEADBEEF);
    preload(4, 32'h11223344);
    run_txn(1'b1, 3'b000, 32'h13, 32'h000000A5, 0, 2, 1'b0, 1'b0, "sb");
    check("sb word4", slave_mem[4], 32'hA5223344);
    preload(8, 32'h80F07F01);
    run_txn(1'b0, 3'b000, 32'h23, 32'h0, 0, 3, 1'b0, 1'b0, "lb");
    run_txn(1'b0, 3'b100, 32'h23, 32'h0, 0, 3, 1'b0, 1'b0, "lbu");
    run_txn(1'b0, 3'b001, 32'h22, 32'h0, 0, 3, 1'b0, 1'b0, "lh");
    run_txn(1'b0, 3'b101, 32'h20, 32'h0, 0, 3, 1'b0, 1'b0, "lhu");
    run_txn(1'b0, 3'b010, 32'h20, 32'h0, 0, 3, 1'b0, 1'b0, "lw");
    run_txn(1'b0, 3'b010, 32'h06, 32'h0, 0, 3, 1'b0, 1'b0, "lw_misaligned");
    run_txn(1'b0, 3'b011, 32'h20, 32'h0, 0, 3, 1'b0, 1'b0, "ld_badf3");
    run_txn(1'b1, 3'b011, 32'h20, 32'h0, 0, 2, 1'b0, 1'b0, "st_badf3");

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      run_txn(w, f3, 32'($urandom_range(0, 63)), $urandom,
              $urandom_range(0, 2), w ? 2 : $urandom_range(1, 3), 1'b0, 1'b0, "rand");
    end

    // Stall then no ack: watchdog completes with error, late ack ignored
    run_txn(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 3, 2, 1'b1, 1'b1, "timeout");

    // Reset while in WAIT
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h24; wdata = 32'h12345678;
    step();
    req = 1'b0;
    step();
    check("pre_reset busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    step();
    check_all_zero("mid_reset");
    reset_n = 1'b1;
    wb_ack = 1'b1; wb_rdata = 32'hFFFFFFFF;
    step();
    wb_ack = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) dcnt++;
      step();
    end
    check("late_ack_after_reset", 32'(dcnt), 32'd0);
    run_txn(1'b1, 3'b010, 32'h24, 32'h0BADBEEF, 0, 2, 1'b0, 1'b0, "sw_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
